// File: rtl/temp_poll_scheduler.sv
// temp_poll_scheduler
//   Periodically asks the I2C master for one temperature-sensor read and
//   captures the 12-bit result. It also drives the heater enable from a
//   setpoint/hysteresis comparison. Failed or timed-out reads are retried
//   immediately. MAX_RETRY consecutive failures park the block in a sticky
//   fault state, which only enable=0 or reset clears.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_enable       1 = run the polling loop, 0 = return to idle
//   i_setpoint     target temperature (sensor LSBs, unsigned)
//   i_hyst         hysteresis half-width (unsigned)
//   o_i2c_start    one-cycle request for one sensor read
//   i_i2c_done     one-cycle pulse: transaction finished
//   i_i2c_err      qualifies i_i2c_done as a failed transaction
//   i_i2c_rdata    sensor word, temperature in bits [15:4]
//   o_temp         last good temperature
//   o_temp_valid   one-cycle pulse when o_temp updates
//   o_heater_on    heater enable
//   o_fault        sticky consecutive-failure indication
module temp_poll_scheduler #(
  parameter int POLL_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int MAX_RETRY      = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [11:0] i_setpoint,
  input  logic [3:0]  i_hyst,
  output logic        o_i2c_start,
  input  logic        i_i2c_done,
  input  logic        i_i2c_err,
  input  logic [15:0] i_i2c_rdata,
  output logic [11:0] o_temp,
  output logic        o_temp_valid,
  output logic        o_heater_on,
  output logic        o_fault
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  localparam logic [PW-1:0] POLL_LOAD  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_POLL = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_EVAL      = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  logic [2:0]    r_state;
  logic [PW-1:0] r_poll_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [RW-1:0] r_retry;
  logic [11:0]   r_temp;
  logic          r_heater;

  logic [11:0]   w_rd_temp;
  logic          w_unused_rdata_lsbs;
  logic          w_done_or_tmo;

  assign w_rd_temp           = i_i2c_rdata[15:4];
  assign w_unused_rdata_lsbs = ^i_i2c_rdata[3:0];
  // Done wins over a coinciding timeout because the done case is decoded first below.
  assign w_done_or_tmo       = i_i2c_done || (r_tmo_cnt == '0);

  // Band edges are formed in 13 bits so that setpoint-hyst can clamp at 0
  // and setpoint+hyst can clamp at full scale without wrapping.
  function automatic logic heater_next(input logic [11:0] t, input logic [11:0] sp,
                                       input logic [3:0] hyst, input logic cur);
    logic [12:0] lo;
    logic [12:0] hi;
    lo = (sp < {8'd0, hyst}) ? 13'd0 : ({1'b0, sp} - {9'd0, hyst});
    hi = {1'b0, sp} + {9'd0, hyst};
    if (hi > 13'd4095) hi = 13'd4095;
    if ({1'b0, t} < lo)       heater_next = 1'b1;
    else if ({1'b0, t} >= hi) heater_next = 1'b0;
    else                      heater_next = cur;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_poll_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_retry    <= '0;
      r_temp     <= '0;
      r_heater   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_heater <= 1'b0;
          r_retry  <= '0;
          if (i_enable) begin
            r_state    <= S_WAIT_POLL;
            r_poll_cnt <= POLL_LOAD;
          end
        end
        S_WAIT_POLL: begin
          if (!i_enable) begin
            r_state  <= S_IDLE;
            r_heater <= 1'b0;
          end else if (r_poll_cnt == '0) begin
            r_state <= S_REQ;
          end else begin
            r_poll_cnt <= r_poll_cnt - PW'(1);
          end
        end
        S_REQ: begin
          r_tmo_cnt <= TMO_LOAD;
          r_state   <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (w_done_or_tmo) begin
            // A disable seen during the transaction takes effect only once the
            // transaction resolves, and then nothing is captured or retried.
            if (!i_enable) begin
              r_state  <= S_IDLE;
              r_heater <= 1'b0;
            end else if (i_i2c_done && !i_i2c_err) begin
              // Heater is decided here so it changes together with temp on EVAL entry.
              r_temp   <= w_rd_temp;
              r_heater <= heater_next(w_rd_temp, i_setpoint, i_hyst, r_heater);
              r_state  <= S_EVAL;
            end else if (r_retry == RETRY_LAST) begin
              r_state  <= S_FAULT;
              r_heater <= 1'b0;
              r_retry  <= '0;
            end else begin
              r_retry <= r_retry + RW'(1);
              r_state <= S_REQ;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
          end
        end
        S_EVAL: begin
          r_retry <= '0;
          if (!i_enable) begin
            r_state  <= S_IDLE;
            r_heater <= 1'b0;
          end else begin
            r_state    <= S_WAIT_POLL;
            r_poll_cnt <= POLL_LOAD;
          end
        end
        S_FAULT: begin
          if (!i_enable) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_i2c_start  = (r_state == S_REQ);
  assign o_temp_valid = (r_state == S_EVAL);
  assign o_fault      = (r_state == S_FAULT);
  assign o_heater_on  = r_heater;
  assign o_temp       = r_temp;

endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Bench for temp_poll_scheduler: directed vector table, multi-cycle corner
// sequences and a randomized transaction run against a transaction-level model.
module tb_temp_poll_scheduler;

  localparam int P = 4;
  localparam int T = 6;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] sp = '0;
  logic [3:0]  hy = '0;
  logic        done = 1'b0;
  logic        err = 1'b0;
  logic [15:0] rdata = '0;
  logic        start;
  logic [11:0] temp;
  logic        tv;
  logic        heat;
  logic        flt;

  temp_poll_scheduler #(
    .POLL_CYCLES(P),
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY(R)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(enable),
    .i_setpoint(sp),
    .i_hyst(hy),
    .o_i2c_start(start),
    .i_i2c_done(done),
    .i_i2c_err(err),
    .i_i2c_rdata(rdata),
    .o_temp(temp),
    .o_temp_valid(tv),
    .o_heater_on(heat),
    .o_fault(flt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction-level model state
  logic [11:0] m_temp = '0;
  logic        m_heat = 1'b0;
  int          m_retry = 0;

  typedef struct {
    logic [11:0] sp;
    logic [3:0]  hy;
    int          kind;   // 0 good, 1 error, 2 no response
    int          d;      // cycles from start to done
    logic [15:0] rd;
    logic        eh;
    logic [11:0] et;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic logic ref_heat(input logic [11:0] t, input logic [11:0] s,
                                    input logic [3:0] h, input logic cur);
    int lo;
    int hi;
    lo = int'(s) - int'(h);
    if (lo < 0) lo = 0;
    hi = int'(s) + int'(h);
    if (hi > 4095) hi = 4095;
    if (int'(t) < lo) return 1'b1;
    if (int'(t) >= hi) return 1'b0;
    return cur;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      if (start) begin
        at = cyc;
        return;
      end
      step();
    end
  endtask

  // One read transaction. Returns the cycle the next start is expected in.
  task automatic txn(input int kind, input int d, input logic [15:0] rd, input int exp_start,
                     output int next_start, output logic faulted,
                     output logic obs_heat, output logic [11:0] obs_temp);
    int at;
    int f;
    faulted = 1'b0;
    next_start = -1;
    obs_heat = heat;
    obs_temp = temp;
    wait_start(at);
    check("start_cycle", at, exp_start);
    if (at < 0) return;
    if (kind == 2) begin
      repeat (T) step();
      f = at + T;
      step();
    end else begin
      repeat (d) step();
      done = 1'b1;
      err = (kind == 1);
      rdata = rd;
      step();
      done = 1'b0;
      err = 1'b0;
      rdata = 16'($urandom);
      f = at + d;
    end
    if (kind == 0) begin
      m_temp = rd[15:4];
      m_heat = ref_heat(m_temp, sp, hy, m_heat);
      m_retry = 0;
      check("temp_valid", tv, 1);
      check("temp", temp, m_temp);
      check("heater", heat, m_heat);
      check("fault_low", flt, 0);
      obs_heat = heat;
      obs_temp = temp;
      next_start = at + d + P + 2;
      step();
      check("temp_valid_pulse", tv, 0);
    end else begin
      m_retry++;
      check("no_valid_on_fail", tv, 0);
      if (m_retry == R) begin
        m_retry = 0;
        m_heat = 1'b0;
        faulted = 1'b1;
        check("fault_set", flt, 1);
        check("fault_heater", heat, 0);
        check("fault_temp_hold", temp, m_temp);
      end else begin
        check("fault_low_retry", flt, 0);
        next_start = f + 1;
      end
    end
  endtask

  task automatic fault_exit(output int next_start);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (start) seen++;
      step();
    end
    check("no_start_in_fault", seen, 0);
    check("fault_sticky", flt, 1);
    enable = 1'b0;
    step();
    check("fault_cleared", flt, 0);
    check("idle_heater", heat, 0);
    check("idle_temp_hold", temp, m_temp);
    enable = 1'b1;
    next_start = cyc + 1 + P;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int at;
    logic fl;
    logic oh;
    logic [11:0] ot;

    vecs[0]  = '{12'h190, 4'd4, 0, 2, 16'h18B3, 1'b1, 12'h18B};
    vecs[1]  = '{12'h190, 4'd4, 0, 1, 16'h18E0, 1'b1, 12'h18E};
    vecs[2]  = '{12'h190, 4'd4, 0, 3, 16'h194F, 1'b0, 12'h194};
    vecs[3]  = '{12'h190, 4'd4, 0, T, 16'h1925, 1'b0, 12'h192};
    vecs[4]  = '{12'h190, 4'd4, 0, 2, 16'h18B0, 1'b1, 12'h18B};
    vecs[5]  = '{12'h190, 4'd4, 1, 2, 16'h0000, 1'b0, 12'h000};
    vecs[6]  = '{12'h190, 4'd4, 1, 4, 16'h0000, 1'b0, 12'h000};
    vecs[7]  = '{12'h190, 4'd4, 0, 1, 16'h1900, 1'b1, 12'h190};
    vecs[8]  = '{12'h190, 4'd4, 1, 1, 16'h0000, 1'b0, 12'h000};
    vecs[9]  = '{12'h190, 4'd4, 2, 0, 16'h0000, 1'b0, 12'h000};
    vecs[10] = '{12'h002, 4'd8, 0, 2, 16'h1000, 1'b0, 12'h100};
    vecs[11] = '{12'h002, 4'd8, 0, 2, 16'h0007, 1'b0, 12'h000};
    vecs[12] = '{12'hFFE, 4'd8, 0, 3, 16'h0100, 1'b1, 12'h010};
    vecs[13] = '{12'hFFE, 4'd8, 0, 2, 16'hFFFA, 1'b0, 12'hFFF};
    vecs[14] = '{12'h100, 4'd0, 0, 1, 16'h0FF0, 1'b1, 12'h0FF};
    vecs[15] = '{12'h100, 4'd0, 0, 5, 16'h1000, 1'b0, 12'h100};

    // Reset state, with enable already high
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    check("rst_start", start, 0);
    check("rst_temp", temp, 0);
    check("rst_valid", tv, 0);
    check("rst_heater", heat, 0);
    check("rst_fault", flt, 0);
    rst_n = 1'b1;
    nxt = cyc + 1 + P;

    // Vector table: regulation, retries, saturation, hyst=0, done/timeout coincide
    for (int i = 0; i < 16; i++) begin
      sp = vecs[i].sp;
      hy = vecs[i].hy;
      txn(vecs[i].kind, vecs[i].d, vecs[i].rd, nxt, nxt, fl, oh, ot);
      if (vecs[i].kind == 0) begin
        check($sformatf("vec%0d_heater", i), oh, vecs[i].eh);
        check($sformatf("vec%0d_temp", i), ot, vecs[i].et);
      end
      if (fl) fault_exit(nxt);
    end

    // Three consecutive timeouts with the heater on -> sticky fault
    sp = 12'h200;
    hy = 4'd2;
    txn(0, 2, 16'h1000, nxt, nxt, fl, oh, ot);
    for (int i = 0; i < 3; i++) begin
      txn(2, 0, 16'h0, nxt, nxt, fl, oh, ot);
      if (fl) fault_exit(nxt);
    end

    // enable dropped during WAIT_DONE: a good done goes to idle with no capture
    wait_start(at);
    check("drop_start_cycle", at, nxt);
    step();
    step();
    enable = 1'b0;
    step();
    done = 1'b1;
    rdata = 16'hABC0;
    step();
    done = 1'b0;
    m_heat = 1'b0;
    check("drop_no_valid", tv, 0);
    check("drop_temp_hold", temp, m_temp);
    check("drop_heater_off", heat, 0);
    check("drop_no_start", start, 0);
    enable = 1'b1;
    nxt = cyc + 1 + P;
    step();
    step();
    done = 1'b1;
    rdata = 16'h7770;
    step();
    done = 1'b0;
    check("stray_done_no_valid", tv, 0);
    check("stray_done_temp", temp, m_temp);
    txn(0, 3, 16'h1230, nxt, nxt, fl, oh, ot);

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int r;
      int kind;
      logic [11:0] t;
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
      sp = 12'($urandom_range(0, 4095));
      hy = 4'($urandom_range(0, 15));
      t = sp + 12'($urandom_range(0, 40)) - 12'd20;
      txn(kind, $urandom_range(1, T), {t, 4'($urandom)}, nxt, nxt, fl, oh, ot);
      if (fl) fault_exit(nxt);
    end

    // Reset asserted during WAIT_DONE; late done must be ignored
    sp = 12'h800;
    hy = 4'd1;
    txn(0, 1, 16'h5A50, nxt, nxt, fl, oh, ot);
    wait_start(at);
    check("rst_mid_start_cycle", at, nxt);
    step();
    step();
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_mid_temp", temp, 0);
    check("rst_mid_heater", heat, 0);
    check("rst_mid_valid", tv, 0);
    check("rst_mid_fault", flt, 0);
    check("rst_mid_start", start, 0);
    m_temp = '0;
    m_heat = 1'b0;
    m_retry = 0;
    step();
    done = 1'b1;
    rdata = 16'h4440;
    step();
    done = 1'b0;
    rst_n = 1'b1;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("late_done_valid", tv, 0);
    check("late_done_temp", temp, 0);
    enable = 1'b1;
    nxt = cyc + 1 + P;
    txn(0, 2, 16'h3210, nxt, nxt, fl, oh, ot);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
